// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner: holds a captured BCD value and walks
// the common-anode selects through the digits with dead time and leading-zero blanking.
module seg_scan #(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp_r;
    logic [3:0]    dp_r;
    logic          lzb_r;

    logic [3:0]    blank;
    logic          dead;
    logic          lit;

    // Slot prescaler and slot index; the index wraps 3 -> 0 on its own width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Display value capture; independent of the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r <= 16'h0000;
            dp_r   <= 4'h0;
            lzb_r  <= 1'b0;
        end else if (load) begin
            disp_r <= digits;
            dp_r   <= dp_in;
            lzb_r  <= lzb;
        end
    end

    // A digit is blank only if it and every digit to its left are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = lzb_r && (disp_r[15:12] == 4'h0);
        blank[2] = blank[3] && (disp_r[11:8] == 4'h0);
        blank[1] = blank[2] && (disp_r[7:4] == 4'h0);
    end

    // Output decode straight from registered state, so reset is visible at once.
    always_comb begin
        dead       = (cnt < CW'(DEAD));
        lit        = !dead && !blank[idx];
        bcd_out    = disp_r[{idx, 2'b00} +: 4];
        an         = lit ? ~(4'b0001 << idx) : 4'b1111;
        dp_n       = lit ? ~dp_r[idx] : 1'b1;
        frame_tick = (idx == 2'd0) && (cnt == '0);
    end

endmodule
